guess_history: RTL
==================

# guess_history

Parametrised turn-history buffer for the code-breaking game. It records each submitted guess together with its black/white score, up to DEPTH turns. It lets the player browse stored turns with up/down buttons, and supports a synchronous new-game clear. It sits between the guess-entry/scoring logic and the display driver, replacing the fixed 4×3-bit, 8-turn history.

## Interface
- PEGS, 4, pegs per guess
- PEG_W, 3, bits per peg (colour code)
- DEPTH, 8, maximum stored turns (≥2)
- Derived, not overridable:
  - TURN_W = $clog2(DEPTH)
  - CNT_W = $clog2(DEPTH+1)
  - SCORE_W = $clog2(PEGS+1)

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = play, 1 = browse
- new_game  in  1  one-cycle pulse; clears history
- store  in  1  one-cycle pulse; record current guess and score
- guess  in  PEGS*PEG_W  guess to store; peg 0 in LSBs
- score_black  in  SCORE_W  pegs correct in position
- score_white  in  SCORE_W  pegs correct in colour only
- btn_up, btn_down  in  1 each  debounced one-cycle pulses (browse)
- sel_guess  out  PEGS*PEG_W  guess of the selected turn
- sel_black, sel_white  out  SCORE_W each  score of the selected turn
- sel_turn  out  TURN_W  index of the selected turn
- count  out  CNT_W  number of stored turns
- last_turn  out  1  high when count == DEPTH-1
- full  out  1  high when count == DEPTH
- drop  out  1  sticky; a store was rejected because full; cleared by new_game or reset

## Operation
- Storage: DEPTH entries of {guess, black, white}. Memory contents are not reset.
- Per-cycle priority: new_game > store > mode-change realignment > btn_up/btn_down.
- new_game:
  - count=0, sel_turn=0, drop=0.
  - All sel_* outputs become 0.
- store in play mode, not full:
  - Writes entry[count].
  - sel_turn ← old count; count ← count+1.
  - sel_* show the new entry (write-through, no stale read).
- store in play mode, full: ignored, drop ← 1.
- store in browse mode: ignored, drop unchanged.
- Play mode without store: sel_turn holds count-1 (0 when count==0).
- Browse mode, count>0:
  - btn_up: sel_turn+1, saturating at count-1.
  - btn_down: sel_turn-1, saturating at 0.
  - Both asserted in the same cycle: no change.
- Browse mode, count==0: buttons ignored; sel_* = 0.
- Mode change, either direction: sel_turn ← count-1 (latest turn), or 0 if empty.
- sel_* always equal the stored entry at sel_turn when count>0, else 0.

## Timing
- Reset values: all outputs 0, sel_turn=0, count=0, drop=0.
- Every output is registered. A store, new_game, button or mode change sampled at edge N is visible on all outputs after edge N.
- Latency is 1 cycle. There is no backpressure; store is always consumed or dropped in its cycle.
- last_turn and full are decoded from the count register. They update in the same cycle as count.
- Reset asserted mid-operation clears state immediately (asynchronous). Deassertion is synchronised upstream.
- Held (multi-cycle) buttons step once per cycle. Edge detection is upstream.

## Structure
- Package game_pkg holds:
  - default PEGS, PEG_W, DEPTH
  - a typed history-entry struct {guess, black, white} built from those widths
  - the SCORE_W helper function
- Sub-module history_cursor: owns sel_turn. It implements saturating up/down, realignment to count-1, and the new_game clear. Parameters: TURN_W, CNT_W.
- Top level owns memory, count, drop and the registered output mux.

## Test plan
- Reset then idle 5 cycles:
  - count=0, full=0, last_turn=0, drop=0
  - sel_guess=0, sel_black=0, sel_white=0, sel_turn=0
- Play mode, store guess=12'h29A with black=1, white=2:
  - next cycle count=1, sel_turn=0, sel_guess=12'h29A, sel_black=1, sel_white=2.
- Store 8 distinct guesses (DEPTH=8), then a 9th store:
  - last_turn=1 after the 7th store; full=1 after the 8th.
  - The 9th store sets drop=1; count stays 8 and sel_turn stays 7.
- Browse mode with count=8:
  - On entry, sel_turn=7.
  - 3× btn_down gives sel_turn=4; sel_guess equals the 5th stored guess.
  - 10× btn_down saturates at 0.
  - btn_up and btn_down together: no change.
  - Back to play: sel_turn=7.
- store and new_game in the same cycle with count=3: count=0, sel_*=0, drop=0; the entry is not recorded.
- Browse mode with count=0: btn_up/btn_down pulses and a store pulse leave count=0, sel_turn=0 and sel_*=0.

Source files
------------

// File: rtl/guess_history_pkg.sv
// Shared widths and the history-entry layout for the code-breaking game datapath.
package game_pkg;

  localparam int PEGS_DEF  = 4;
  localparam int PEG_W_DEF = 3;
  localparam int DEPTH_DEF = 8;

  function automatic int score_w(input int pegs);
    return $clog2(pegs + 1);
  endfunction

  localparam int SCORE_W_DEF = score_w(PEGS_DEF);

  // Default-width entry as seen by the scoring logic and the display driver.
  typedef struct packed {
    logic [PEGS_DEF*PEG_W_DEF-1:0] guess;
    logic [SCORE_W_DEF-1:0]        black;
    logic [SCORE_W_DEF-1:0]        white;
  } hist_entry_t;

endpackage

// File: rtl/history_cursor.sv
// Selected-turn cursor: saturating browse stepping, realignment on mode change, new-game clear.
module history_cursor #(
  parameter int TURN_W = 3,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              new_game,
  input  logic              store_ok,
  input  logic              mode,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic [CNT_W-1:0]  count,
  output logic [TURN_W-1:0] sel_turn,
  output logic [TURN_W-1:0] sel_turn_nxt
);

  logic              mode_q;
  logic [TURN_W-1:0] latest;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_turn <= '0;
      mode_q   <= 1'b0;
    end else begin
      sel_turn <= sel_turn_nxt;
      mode_q   <= mode;
    end
  end

  always_comb begin
    latest       = (count == '0) ? '0 : TURN_W'(count - CNT_W'(1));
    sel_turn_nxt = sel_turn;
    if (new_game) begin
      sel_turn_nxt = '0;
    end else if (store_ok) begin
      // Accepted stores never happen when full, so the old count fits in TURN_W.
      sel_turn_nxt = TURN_W'(count);
    end else if (mode != mode_q) begin
      sel_turn_nxt = latest;
    end else if (mode && (count != '0)) begin
      if (btn_up && !btn_down && (sel_turn != latest))
        sel_turn_nxt = sel_turn + TURN_W'(1);
      else if (btn_down && !btn_up && (sel_turn != '0))
        sel_turn_nxt = sel_turn - TURN_W'(1);
    end
  end

endmodule

// File: rtl/guess_history.sv
// Turn-history buffer: stores guesses with scores, exposes a registered view of the selected turn.
module guess_history
  import game_pkg::*;
#(
  parameter  int PEGS    = PEGS_DEF,
  parameter  int PEG_W   = PEG_W_DEF,
  parameter  int DEPTH   = DEPTH_DEF,
  localparam int TURN_W  = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int SCORE_W = score_w(PEGS),
  localparam int GUESS_W = PEGS * PEG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic               new_game,
  input  logic               store,
  input  logic [GUESS_W-1:0] guess,
  input  logic [SCORE_W-1:0] score_black,
  input  logic [SCORE_W-1:0] score_white,
  input  logic               btn_up,
  input  logic               btn_down,
  output logic [GUESS_W-1:0] sel_guess,
  output logic [SCORE_W-1:0] sel_black,
  output logic [SCORE_W-1:0] sel_white,
  output logic [TURN_W-1:0]  sel_turn,
  output logic [CNT_W-1:0]   count,
  output logic               last_turn,
  output logic               full,
  output logic               drop
);

  typedef struct packed {
    logic [GUESS_W-1:0] guess;
    logic [SCORE_W-1:0] black;
    logic [SCORE_W-1:0] white;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            sel_q;
  entry_t            wr_entry;
  logic              store_ok;
  logic [CNT_W-1:0]  count_nxt;
  logic [TURN_W-1:0] sel_turn_nxt;

  assign full      = (count == CNT_W'(DEPTH));
  assign last_turn = (count == CNT_W'(DEPTH - 1));
  assign store_ok  = store && !mode && !full && !new_game;
  assign wr_entry  = '{guess: guess, black: score_black, white: score_white};

  always_comb begin
    count_nxt = count;
    if (new_game)      count_nxt = '0;
    else if (store_ok) count_nxt = count + CNT_W'(1);
  end

  history_cursor #(
    .TURN_W (TURN_W),
    .CNT_W  (CNT_W)
  ) u_cursor (
    .clk          (clk),
    .rst_n        (rst_n),
    .new_game     (new_game),
    .store_ok     (store_ok),
    .mode         (mode),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .count        (count),
    .sel_turn     (sel_turn),
    .sel_turn_nxt (sel_turn_nxt)
  );

  always_ff @(posedge clk) begin
    if (store_ok) mem[TURN_W'(count)] <= wr_entry;
  end

  // Output view is loaded from next-state so it lines up with count/sel_turn; stores bypass the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      drop  <= 1'b0;
      sel_q <= '0;
    end else begin
      count <= count_nxt;
      if (new_game)                     drop <= 1'b0;
      else if (store && !mode && full)  drop <= 1'b1;
      if (new_game || (count_nxt == '0)) sel_q <= '0;
      else if (store_ok)                 sel_q <= wr_entry;
      else                               sel_q <= mem[sel_turn_nxt];
    end
  end

  assign sel_guess = sel_q.guess;
  assign sel_black = sel_q.black;
  assign sel_white = sel_q.white;

endmodule
